// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: word, RAM status and arbiter FSM state.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned PERF_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    // Index width for n items; never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above rr_ptr, wrapping.
module rr_pick
    import cpu_types_pkg::*;
#(
    parameter  int unsigned N  = 4,
    localparam int unsigned PW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] rr_ptr,
    output logic [PW-1:0] grant_idx,
    output logic          any
);

    int unsigned w_idx;

    // Scan N positions starting at rr_ptr; the first hit wins.
    always_comb begin
        grant_idx = '0;
        any       = 1'b0;
        w_idx     = 0;
        for (int unsigned k = 0; k < N; k++) begin
            w_idx = (32'(rr_ptr) + k) % N;
            if (!any && req[PW'(w_idx)]) begin
                any       = 1'b1;
                grant_idx = PW'(w_idx);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter_rr.sv
// Round-robin RAM arbiter between CPUS cores (icache + dcache each) and one RAM.
// Grant is held for a whole RAM transaction; dropping the request aborts it.
// Optional per-requester completion counters: define MEM_ARB_PERF_EN.
module mem_arbiter_rr
    import cpu_types_pkg::*;
#(
    parameter  int unsigned CPUS = 2,
    parameter  int unsigned AW   = 32,
    parameter  int unsigned DW   = 32,
    localparam int unsigned REQS = 2 * CPUS,
    localparam int unsigned PW   = idx_w(REQS),
    localparam int unsigned CW   = idx_w(CPUS)
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic [CPUS-1:0]          iREN,
    input  logic [CPUS-1:0][AW-1:0]  iaddr,
    input  logic [CPUS-1:0]          dREN,
    input  logic [CPUS-1:0]          dWEN,
    input  logic [CPUS-1:0][AW-1:0]  daddr,
    input  logic [CPUS-1:0][DW-1:0]  dstore,
    output logic [CPUS-1:0]          iwait,
    output logic [CPUS-1:0]          dwait,
    output logic [CPUS-1:0][DW-1:0]  iload,
    output logic [CPUS-1:0][DW-1:0]  dload,
    output logic                     ramREN,
    output logic                     ramWEN,
    output logic [AW-1:0]            ramaddr,
    output logic [DW-1:0]            ramstore,
    input  logic [DW-1:0]            ramload,
    input  ramstate_t                ramstate
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [REQS-1:0][PERF_W-1:0] perf_grants
`endif
);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic [PW-1:0]     r_owner;
    logic [PW-1:0]     w_owner_nxt;
    logic [PW-1:0]     r_rr_ptr;
    logic [PW-1:0]     w_rr_ptr_nxt;
    logic [REQS-1:0]   w_req;
    logic [PW-1:0]     w_grant_idx;
    logic              w_any;
    logic [CW-1:0]     w_core;
    logic              w_is_icache;
    logic              w_owner_req;
    logic              w_done;

    // Requester vector: even index = dcache, odd index = icache of the same core.
    for (genvar g = 0; g < CPUS; g++) begin : g_req
        assign w_req[2*g]   = dREN[g] | dWEN[g];
        assign w_req[2*g+1] = iREN[g];
        assign iload[g]     = ramload;
        assign dload[g]     = ramload;
    end

    assign w_core      = CW'(r_owner >> 1);
    assign w_is_icache = r_owner[0];
    assign w_owner_req = w_req[r_owner];

    rr_pick #(
        .N (REQS)
    ) u_rr_pick (
        .req       (w_req),
        .rr_ptr    (r_rr_ptr),
        .grant_idx (w_grant_idx),
        .any       (w_any)
    );

    // State, owner and round-robin pointer registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state  <= IDLE;
            r_owner  <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_owner  <= w_owner_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
        end
    end

    // Next-state logic and per-port wait outputs; ACCESS takes priority over an abort.
    always_comb begin
        w_state_nxt  = r_state;
        w_owner_nxt  = r_owner;
        w_rr_ptr_nxt = r_rr_ptr;
        w_done       = 1'b0;
        iwait        = '1;
        dwait        = '1;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_owner_nxt = w_grant_idx;
                    w_state_nxt = XFER;
                end
            end
            XFER: begin
                if (ramstate == ACCESS) begin
                    w_done       = 1'b1;
                    w_rr_ptr_nxt = (r_owner == PW'(REQS - 1)) ? '0 : r_owner + PW'(1);
                    w_state_nxt  = IDLE;
                    if (w_is_icache) begin
                        iwait[w_core] = 1'b0;
                    end else begin
                        dwait[w_core] = 1'b0;
                    end
                end else if (!w_owner_req) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // RAM strobes, address and write data steered from the current owner.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        if (r_state == XFER) begin
            if (w_is_icache) begin
                ramREN  = 1'b1;
                ramaddr = iaddr[w_core];
            end else begin
                ramREN   = dREN[w_core];
                ramWEN   = dWEN[w_core] & ~dREN[w_core];
                ramaddr  = daddr[w_core];
                ramstore = dstore[w_core];
            end
        end
    end

`ifdef MEM_ARB_PERF_EN
    logic [REQS-1:0][PERF_W-1:0] r_perf;

    // Saturating completion counters; aborts never reach w_done.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_perf <= '0;
        end else if (w_done && (r_perf[r_owner] != '1)) begin
            r_perf[r_owner] <= r_perf[r_owner] + PERF_W'(1);
        end
    end

    assign perf_grants = r_perf;
`endif

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Scoreboard bench for mem_arbiter_rr (CPUS=2) with a latency-programmable RAM model.
module tb_mem_arbiter_rr;
    import cpu_types_pkg::*;

    typedef struct {
        int          port;
        logic [31:0] addr;
        logic        wen;
        logic [31:0] store;
    } exp_t;

    logic             CLK;
    logic             nRST;
    logic [1:0]       iREN, dREN, dWEN;
    logic [1:0][31:0] iaddr, daddr, dstore, iload, dload;
    logic [1:0]       iwait, dwait;
    logic             ramREN, ramWEN;
    logic [31:0]      ramaddr, ramstore, ramload;
    ramstate_t        ramstate;
`ifdef MEM_ARB_PERF_EN
    logic [3:0][31:0] perf_grants;
`endif

    int unsigned lat, err_n, ram_cnt;
    int          n_checks, n_pass;
    exp_t        sb[$];

    mem_arbiter_rr #(.CPUS(2), .AW(32), .DW(32)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .iwait    (iwait),
        .dwait    (dwait),
        .iload    (iload),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate)
`ifdef MEM_ARB_PERF_EN
        ,
        .perf_grants (perf_grants)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // RAM model: ERROR for err_n strobe cycles, BUSY until lat, then ACCESS.
    always @(posedge CLK) begin
        if (!(ramREN || ramWEN)) ram_cnt <= 0;
        else                     ram_cnt <= ram_cnt + 1;
    end

    always_comb begin
        ramstate = FREE;
        if (ramREN || ramWEN) begin
            if (ram_cnt < err_n)    ramstate = ERROR;
            else if (ram_cnt < lat) ramstate = BUSY;
            else                    ramstate = ACCESS;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Wait vector in requester order: bit0 d0, bit1 i0, bit2 d1, bit3 i1.
    function automatic logic [3:0] waits_vec();
        return {iwait[1], dwait[1], iwait[0], dwait[0]};
    endfunction

    function automatic int first_low(input logic [3:0] w);
        int p;
        p = -1;
        for (int k = 0; k < 4; k++) if (!w[k] && p < 0) p = k;
        return p;
    endfunction

    // Ack monitor: every wait pulse pops and checks one scoreboard entry.
    always @(negedge CLK) begin
        logic [3:0] w;
        logic [3:0] lo;
        exp_t       e;
        if (nRST) begin
            w  = waits_vec();
            lo = ~w;
            if (w != 4'hF) begin
                chk("ack_onehot", 64'($countones(lo)), 64'd1);
                if (sb.size() == 0) begin
                    chk("ack_unexpected", 64'(lo), 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("ack_port", 64'(first_low(w)), 64'(e.port));
                    chk("ack_addr", 64'(ramaddr), 64'(e.addr));
                    chk("ack_wen", 64'(ramWEN), 64'(e.wen));
                    if (e.wen) chk("ack_store", 64'(ramstore), 64'(e.store));
                end
            end
        end
    end

    task automatic drop_req(input int p);
        case (p)
            0: begin dREN[0] = 1'b0; dWEN[0] = 1'b0; end
            1: iREN[0] = 1'b0;
            2: begin dREN[1] = 1'b0; dWEN[1] = 1'b0; end
            default: iREN[1] = 1'b0;
        endcase
    endtask

    // Collect n acks (bounded); drop each acked request unless kept.
    task automatic run_acks(input int n, input logic [3:0] keep);
        int         got;
        int         budget;
        int         p;
        logic [3:0] w;
        got    = 0;
        budget = 400;
        while (got < n && budget > 0) begin
            @(negedge CLK);
            budget--;
            w = waits_vec();
            if (w != 4'hF) begin
                got++;
                p = first_low(w);
                @(posedge CLK);
                #1;
                if (!keep[p]) drop_req(p);
            end
        end
        chk("acks_seen", 64'(got), 64'(n));
    endtask

    task automatic do_reset();
        nRST   = 1'b0;
        iREN   = '0;
        dREN   = '0;
        dWEN   = '0;
        iaddr  = '0;
        daddr  = '0;
        dstore = '0;
        lat    = 0;
        err_n  = 0;
        sb.delete();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        ramload  = '0;
        nRST     = 1'b0;
        iREN = '0; dREN = '0; dWEN = '0;
        iaddr = '0; daddr = '0; dstore = '0;
        lat = 0; err_n = 0;

        // Reset values
        #2;
        chk("rst_ramREN", 64'(ramREN), 64'd0);
        chk("rst_ramWEN", 64'(ramWEN), 64'd0);
        chk("rst_iwait", 64'(iwait), 64'h3);
        chk("rst_dwait", 64'(dwait), 64'h3);
        do_reset();

        // Single read, RAM ACCESS two cycles after the strobe
        lat     = 2;
        dREN[0] = 1'b1;
        daddr[0] = 32'h40;
        sb.push_back('{port: 0, addr: 32'h40, wen: 1'b0, store: 32'h0});
        @(posedge CLK);
        #1;
        chk("rd_ramREN", 64'(ramREN), 64'd1);
        chk("rd_ramaddr", 64'(ramaddr), 64'h40);
        chk("rd_dwait_hi", 64'(dwait), 64'h3);
        run_acks(1, 4'h0);
        @(negedge CLK);
        chk("rd_pulse_width", 64'(dwait), 64'h3);
        chk("rd_bubble", 64'(ramREN), 64'd0);
        ramload = 32'h1234_5678;
        #1;
        chk("load_d1", 64'(dload[1]), 64'h1234_5678);
        chk("load_i0", 64'(iload[0]), 64'h1234_5678);

        // Contention: all four requesters continuously, 1-cycle RAM
        do_reset();
        daddr[0] = 32'h100; iaddr[0] = 32'h200;
        daddr[1] = 32'h110; iaddr[1] = 32'h210;
        for (int r = 0; r < 2; r++) begin
            sb.push_back('{port: 0, addr: 32'h100, wen: 1'b0, store: 32'h0});
            sb.push_back('{port: 1, addr: 32'h200, wen: 1'b0, store: 32'h0});
            sb.push_back('{port: 2, addr: 32'h110, wen: 1'b0, store: 32'h0});
            sb.push_back('{port: 3, addr: 32'h210, wen: 1'b0, store: 32'h0});
        end
        dREN = 2'b11;
        iREN = 2'b11;
        run_acks(8, 4'hF);
        dREN = '0;
        iREN = '0;
        chk("rr_sb_empty", 64'(sb.size()), 64'd0);
`ifdef MEM_ARB_PERF_EN
        for (int p = 0; p < 4; p++) chk("perf_count", 64'(perf_grants[p]), 64'd2);
`endif

        // Write from core 1 dcache, then read-wins when both strobes asserted
        do_reset();
        lat       = 1;
        dWEN[1]   = 1'b1;
        daddr[1]  = 32'h80;
        dstore[1] = 32'hDEAD_BEEF;
        sb.push_back('{port: 2, addr: 32'h80, wen: 1'b1, store: 32'hDEAD_BEEF});
        @(posedge CLK);
        #1;
        chk("wr_ramWEN", 64'(ramWEN), 64'd1);
        chk("wr_ramREN", 64'(ramREN), 64'd0);
        chk("wr_ramstore", 64'(ramstore), 64'hDEAD_BEEF);
        chk("wr_ramaddr", 64'(ramaddr), 64'h80);
        chk("wr_iwait", 64'(iwait), 64'h3);
        run_acks(1, 4'h0);
        @(negedge CLK);
        dREN[1]  = 1'b1;
        dWEN[1]  = 1'b1;
        daddr[1] = 32'h84;
        sb.push_back('{port: 2, addr: 32'h84, wen: 1'b0, store: 32'h0});
        @(posedge CLK);
        #1;
        chk("rw_ramREN", 64'(ramREN), 64'd1);
        chk("rw_ramWEN", 64'(ramWEN), 64'd0);
        run_acks(1, 4'h0);

        // Abort: icache 0 drops its request while RAM is BUSY
        do_reset();
        lat      = 100;
        iREN[0]  = 1'b1;
        iaddr[0] = 32'h300;
        @(posedge CLK);
        #1;
        chk("ab_ramREN", 64'(ramREN), 64'd1);
        chk("ab_ramaddr", 64'(ramaddr), 64'h300);
        repeat (2) @(posedge CLK);
        #1;
        iREN[0] = 1'b0;
        @(posedge CLK);
        #1;
        chk("ab_idle", 64'(ramREN), 64'd0);
        repeat (3) begin
            @(negedge CLK);
            chk("ab_no_pulse", 64'(iwait), 64'h3);
        end
        lat      = 0;
        iaddr[1] = 32'h310;
        iREN     = 2'b11;
        sb.push_back('{port: 1, addr: 32'h300, wen: 1'b0, store: 32'h0});
        sb.push_back('{port: 3, addr: 32'h310, wen: 1'b0, store: 32'h0});
        run_acks(2, 4'h0);

        // ERROR for three cycles, then ACCESS
        do_reset();
        err_n    = 3;
        lat      = 3;
        dREN[1]  = 1'b1;
        daddr[1] = 32'h500;
        sb.push_back('{port: 2, addr: 32'h500, wen: 1'b0, store: 32'h0});
        @(posedge CLK);
        repeat (3) begin
            @(negedge CLK);
            chk("err_strobe", 64'(ramREN), 64'd1);
            chk("err_wait", 64'(dwait), 64'h3);
        end
        run_acks(1, 4'h0);
        err_n = 0;

        // Asynchronous reset in the middle of a transaction
        @(negedge CLK);
        lat      = 100;
        dREN[0]  = 1'b1;
        daddr[0] = 32'h600;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("mid_pre_strobe", 64'(ramREN), 64'd1);
        #2;
        nRST = 1'b0;
        #1;
        chk("mid_ramREN", 64'(ramREN), 64'd0);
        chk("mid_ramWEN", 64'(ramWEN), 64'd0);
        chk("mid_iwait", 64'(iwait), 64'h3);
        chk("mid_dwait", 64'(dwait), 64'h3);
`ifdef MEM_ARB_PERF_EN
        for (int p = 0; p < 4; p++) chk("mid_perf_zero", 64'(perf_grants[p]), 64'd0);
`endif
        dREN = '0;
        @(negedge CLK);
        nRST = 1'b1;
        repeat (2) @(negedge CLK);
        chk("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
